// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker
//   Keeps an in-order record of branch predictions between fetch and execute.
//   Fetch pushes {pc low bits, prediction}. Execute pops the oldest entry,
//   compares it with the real outcome and emits the history-table update.
//   On a mispredict it emits a one-cycle flush, clears the queue and spends
//   one enabled cycle in RECOVER, where all inputs are ignored.
//
//   Optional feature macro: BRANCH_TRACKER_STATS_EN adds saturating
//   resolved_count / mispredict_count outputs.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  pipeline advance (0 = hold state, pulses register 0)
//   push_valid/pc/pred  fetch-side record of a predicted branch
//   resolve_valid       execute resolved the oldest branch
//   resolve_taken       conditional branch taken
//   resolve_jumped      unconditional jump
//   full, empty         occupancy status (combinational from count)
//   flush               registered mispredict pulse
//   bht_en              registered history-table write enable
//   bht_write_addr      registered pc of the resolved entry
//   bht_was_taken       registered copy of resolve_taken
//   bht_jumped          registered copy of resolve_jumped
//   resolved_count      (stats only) number of pops, saturating
//   mispredict_count    (stats only) number of mispredicts, saturating
module branch_outcome_tracker #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_valid,
  input  logic [LOWER-1:0] push_pc,
  input  logic             push_pred,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             resolve_jumped,
  output logic             full,
  output logic             empty,
  output logic             flush,
  output logic             bht_en,
  output logic [LOWER-1:0] bht_write_addr,
  output logic             bht_was_taken,
  output logic             bht_jumped
`ifdef BRANCH_TRACKER_STATS_EN
  ,
  output logic [15:0]      resolved_count,
  output logic [15:0]      mispredict_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t           state_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  logic [LOWER-1:0] pc_mem   [DEPTH];
  logic             pred_mem [DEPTH];

  logic pop;
  logic push_ok;
  logic actual_taken;
  logic mispredict;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // Pop and push are only meaningful while advancing in NORMAL. A push into
  // a full queue is allowed when the oldest entry leaves in the same cycle.
  // A mispredict discards any same-cycle push along with the rest of the queue.
  always_comb begin
    actual_taken = resolve_taken | resolve_jumped;
    pop          = en && (state_reg == NORMAL) && resolve_valid && !empty;
    mispredict   = pop && (actual_taken != pred_mem[head_reg]);
    push_ok      = en && (state_reg == NORMAL) && push_valid
                   && (!full || pop) && !mispredict;
  end

  // Storage has no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail_reg]   <= push_pc;
      pred_mem[tail_reg] <= push_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= NORMAL;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      flush          <= 1'b0;
      bht_en         <= 1'b0;
      bht_write_addr <= '0;
      bht_was_taken  <= 1'b0;
      bht_jumped     <= 1'b0;
    end else begin
      // Pulse outputs default low; they only rise for the cycle after a pop.
      flush  <= 1'b0;
      bht_en <= 1'b0;
      if (en) begin
        case (state_reg)
          NORMAL: begin
            if (pop) begin
              bht_en         <= 1'b1;
              bht_write_addr <= pc_mem[head_reg];
              bht_was_taken  <= resolve_taken;
              bht_jumped     <= resolve_jumped;
            end
            if (mispredict) begin
              flush     <= 1'b1;
              head_reg  <= '0;
              tail_reg  <= '0;
              count_reg <= '0;
              state_reg <= RECOVER;
            end else begin
              if (pop)
                head_reg <= head_reg + 1'b1;
              if (push_ok)
                tail_reg <= tail_reg + 1'b1;
              case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
              endcase
            end
          end
          RECOVER: state_reg <= NORMAL;
          default: state_reg <= NORMAL;
        endcase
      end
    end
  end

`ifdef BRANCH_TRACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_count   <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop && resolved_count != 16'hFFFF)
        resolved_count <= resolved_count + 16'd1;
      if (mispredict && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Testbench for branch_outcome_tracker: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_branch_outcome_tracker;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             push_valid;
  logic [LOWER-1:0] push_pc;
  logic             push_pred;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             resolve_jumped;
  logic             full;
  logic             empty;
  logic             flush;
  logic             bht_en;
  logic [LOWER-1:0] bht_write_addr;
  logic             bht_was_taken;
  logic             bht_jumped;
`ifdef BRANCH_TRACKER_STATS_EN
  logic [15:0]      resolved_count;
  logic [15:0]      mispredict_count;
`endif

  branch_outcome_tracker #(.LOWER(LOWER), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .push_valid     (push_valid),
    .push_pc        (push_pc),
    .push_pred      (push_pred),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_jumped (resolve_jumped),
    .full           (full),
    .empty          (empty),
    .flush          (flush),
    .bht_en         (bht_en),
    .bht_write_addr (bht_write_addr),
    .bht_was_taken  (bht_was_taken),
    .bht_jumped     (bht_jumped)
`ifdef BRANCH_TRACKER_STATS_EN
    ,
    .resolved_count   (resolved_count),
    .mispredict_count (mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of outstanding predictions plus a flag
  // saying the next enabled cycle is the post-mispredict dead cycle.
  typedef struct {
    logic [LOWER-1:0] pc;
    logic             pred;
  } entry_t;

  entry_t m_q[$];
  bit     m_recover;
  logic   e_flush, e_bht_en, e_taken, e_jumped;
  logic [LOWER-1:0] e_addr;
  int     m_resolved, m_mispred;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (txn %0d)", tag, obs, expv, txn);
    end
  endtask

  // One clock cycle: drive inputs, check occupancy flags, advance the model,
  // then check the registered outputs after the edge.
  task automatic step(input logic r, input logic e, input logic pv,
                      input logic [LOWER-1:0] pc, input logic pp,
                      input logic rv, input logic rt, input logic rj);
    entry_t head;
    bit     was_full, did_pop, mis, push_ok;
    @(negedge clk);
    rst = r; en = e; push_valid = pv; push_pc = pc; push_pred = pp;
    resolve_valid = rv; resolve_taken = rt; resolve_jumped = rj;
    #1;
    check("full",  {31'd0, full},  {31'd0, m_q.size() == DEPTH});
    check("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});

    e_flush = 1'b0; e_bht_en = 1'b0;
    if (r) begin
      m_q.delete(); m_recover = 0;
      e_addr = '0; e_taken = 1'b0; e_jumped = 1'b0;
      m_resolved = 0; m_mispred = 0;
    end else if (e) begin
      if (m_recover) begin
        m_recover = 0;
      end else begin
        was_full = (m_q.size() == DEPTH);
        did_pop  = rv && (m_q.size() != 0);
        mis      = 0;
        if (did_pop) begin
          head = m_q.pop_front();
          e_bht_en = 1'b1; e_addr = head.pc; e_taken = rt; e_jumped = rj;
          mis = ((rt | rj) != head.pred);
          if (m_resolved < 65535) m_resolved++;
          if (mis && m_mispred < 65535) m_mispred++;
        end
        push_ok = pv && (!was_full || did_pop);
        if (mis) begin
          e_flush = 1'b1; m_q.delete(); m_recover = 1;
        end else if (push_ok) begin
          m_q.push_back('{pc: pc, pred: pp});
        end
      end
    end

    @(posedge clk);
    #1;
    $display("txn %0d rst=%0b en=%0b push=%0b pc=%0d pred=%0b res=%0b t=%0b j=%0b -> flush=%0b bht_en=%0b addr=%0d occ=%0d",
             txn, r, e, pv, pc, pp, rv, rt, rj, flush, bht_en, bht_write_addr, m_q.size());
    check("flush",  {31'd0, flush},  {31'd0, e_flush});
    check("bht_en", {31'd0, bht_en}, {31'd0, e_bht_en});
    if (e_bht_en || r) begin
      check("bht_write_addr", {27'd0, bht_write_addr}, {27'd0, e_addr});
      check("bht_was_taken",  {31'd0, bht_was_taken},  {31'd0, e_taken});
      check("bht_jumped",     {31'd0, bht_jumped},     {31'd0, e_jumped});
    end
`ifdef BRANCH_TRACKER_STATS_EN
    check("resolved_count",   {16'd0, resolved_count},   m_resolved);
    check("mispredict_count", {16'd0, mispredict_count}, m_mispred);
`endif
    txn++;
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push_valid = 1'b0; push_pc = '0; push_pred = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_jumped = 1'b0;
    m_resolved = 0; m_mispred = 0; m_recover = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1, 1);

    // Single correct prediction
    step(0, 1, 1, 3, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    idle();

    // Mispredict, same-cycle push and RECOVER-cycle push both dropped
    step(0, 1, 1, 5, 0, 0, 0, 0);
    step(0, 1, 1, 7, 1, 0, 0, 0);
    step(0, 1, 1, 9, 1, 0, 0, 0);
    step(0, 1, 1, 11, 0, 1, 1, 0);
    step(0, 1, 1, 13, 1, 1, 1, 0);
    idle();

    // Fill to DEPTH, overflow push, push+pop at full, drain in order
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 5'(20 + i), 5'(i) % 2 == 1, 0, 0, 0);
    step(0, 1, 1, 30, 0, 0, 0, 0);
    step(0, 1, 1, 31, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    idle();

    // Resolve while empty; push+resolve at empty
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 2, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1);

    // en=0 hold with inputs active, then resume
    step(0, 1, 1, 6, 0, 0, 0, 0);
    step(0, 1, 1, 8, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 17, 1, 1, 1, 1);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    idle();

    // Mispredict then en=0 stalls inside RECOVER
    step(0, 1, 1, 12, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 14, 0, 0, 0, 0);
    step(0, 1, 1, 15, 0, 0, 0, 0);
    step(0, 1, 1, 16, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);

    // Three correct resolves and one mispredict, then reset mid-queue
    for (int i = 0; i < 4; i++) step(0, 1, 1, 5'(i), 1'b1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    idle();
    step(0, 1, 1, 9, 0, 0, 0, 0);
    step(0, 1, 1, 10, 0, 0, 0, 0);
    step(1, 1, 1, 11, 0, 1, 0, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 6,
           5'($urandom),
           1'($urandom),
           $urandom_range(0, 1) == 1,
           1'($urandom),
           $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_outcome_tracker.md
# branch_outcome_tracker

Tracks branch predictions between fetch and execute. At fetch it records the lower PC bits and the prediction from the branch history table in an in-order queue. At execute it pops the oldest entry, compares it with the real outcome, and produces the history-table update (write address, taken/jumped) plus a one-cycle flush pulse on a mispredict. It sits downstream of the history table's prediction output and upstream of its write port.

## Interface
- `LOWER`, 5, PC low bits per entry; matches the history table index width
- `DEPTH`, 4, queue entries; power of two, ≥2
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  pipeline advance; 0 = hold all state, pulse outputs register 0
- `push_valid`  in  1  fetch issued a predicted instruction
- `push_pc`  in  LOWER  PC low bits of that instruction
- `push_pred`  in  1  prediction used at fetch (1 = taken)
- `resolve_valid`  in  1  execute resolved oldest branch
- `resolve_taken`  in  1  conditional branch taken
- `resolve_jumped`  in  1  unconditional jump
- `full`  out  1  occupancy == DEPTH (combinational from count)
- `empty`  out  1  occupancy == 0 (combinational from count)
- `flush`  out  1  registered mispredict pulse
- `bht_en`  out  1  registered history-table write enable
- `bht_write_addr`  out  LOWER  registered PC of resolved entry
- `bht_was_taken`, `bht_jumped`  out  1 each  registered copies of resolve inputs

## Operation
- Storage: circular buffer of DEPTH × {pc, pred}; head/tail pointers are log2(DEPTH) bits and wrap naturally; occupancy counter is log2(DEPTH)+1 bits.
- FSM states: NORMAL and RECOVER. Reset goes to NORMAL.
- NORMAL, en=1:
  - Push is accepted when push_valid and (!full or a pop occurs in the same cycle). A push while full without a pop is dropped, and state is unchanged.
  - Pop happens when resolve_valid and !empty. resolve_valid while empty is ignored, and no outputs fire.
  - Simultaneous push and pop: occupancy is unchanged. At occupancy 0 only the push takes effect; the pop is ignored.
  - Actual outcome = resolve_taken | resolve_jumped. A mispredict is a pop where actual != stored pred.
  - Every pop: next cycle bht_en=1, bht_write_addr=stored pc, and bht_was_taken/bht_jumped = the inputs.
  - On a mispredict, additionally:
    - next cycle flush=1;
    - the queue is cleared (head=tail=0, count=0), discarding all younger entries and any same-cycle push;
    - the FSM goes to RECOVER.
- RECOVER (exactly one enabled cycle):
  - pushes and resolves are ignored;
  - flush and bht_en register 0;
  - the FSM returns to NORMAL.
- en=0:
  - pointers, count, storage and FSM hold, and RECOVER does not advance;
  - flush and bht_en register 0.
- Reset: pointers, count and all outputs = 0 (full=0, empty=1), FSM=NORMAL. Reset overrides en and all inputs. A reset during RECOVER or with a non-empty queue discards everything.

## Timing
- Resolve to bht_* and flush: 1 cycle, registered, single-cycle pulses.
- Push to poppable: 1 cycle. An entry pushed in cycle N can be popped in cycle N+1.
- After a mispredict resolve in cycle N:
  - flush is high in N+1;
  - the cycle after the resolve (N+1) is RECOVER, and its inputs are dropped;
  - pushes are accepted again from N+2.
- full/empty reflect the count at the start of the cycle.

## Configuration
- `BRANCH_TRACKER_STATS_EN` defined: adds outputs `resolved_count` [15:0] and `mispredict_count` [15:0]. They count pops and mispredicts, saturate at 16'hFFFF, and are reset to 0 by rst.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then push pc=3/pred=0 and resolve taken=0, jumped=0 the next cycle → bht_en=1, bht_write_addr=3, flush=0, empty=1 afterwards.
- Push pc=5/pred=0, 7/pred=1, 9/pred=1, then resolve pc 5 with taken=1 → flush=1 one cycle later, bht_write_addr=5, count=0, and a push in the RECOVER cycle is dropped (empty stays 1).
- Push 4 entries (DEPTH=4) → full=1; a 5th push alone is dropped; push+resolve together keeps full=1, and the 5th pc is later popped in order.
- Resolve_valid while empty → bht_en=0, flush=0, no pointer change.
- en=0 for 3 cycles with push_valid/resolve_valid high → count, head and tail unchanged, bht_en=0. Resume with en=1 → normal operation.
- With `BRANCH_TRACKER_STATS_EN`: 3 correct resolves + 1 mispredict → resolved_count=4, mispredict_count=1. rst mid-queue → both counters 0, empty=1.
